route_sequencer: RTL and testbench
==================================

# route_sequencer

Junction-decision controller for the drive block. It stores a pre-loaded route: an ordered list of turn directions, one per junction. It presents the current direction to the drive block on `tdDir` and advances one entry each time the drive block completes a junction manoeuvre. A timeout watchdog forces STOP if a manoeuvre never completes.

## Interface
- `DEPTH`, 16: route table entries (power of two, 2–64).
- `TIMEOUT_CYC`, 200_000_000: max cycles allowed in TURN before fault (4 s at 50 MHz).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wrEn` in 1: append `wrDir` to the route table (1-cycle strobe).
- `wrDir` in 3: direction code. STOP=0, STRAIGHT=1, LEFT=2, RIGHT=3, BACK=4; codes 5–7 are stored as STOP.
- `start` in 1: begin executing the route from entry 0.
- `clear` in 1: empty the table, clear `fault`, go to IDLE.
- `jncArrive` in 1: pulse; drive block has entered its junction state.
- `jncDone` in 1: pulse; drive block has returned to its drive state.
- `tdDir` out 3: direction for the current junction (registered).
- `count` out $clog2(DEPTH)+1: entries stored.
- `full` out 1: `count == DEPTH`.
- `busy` out 1: state is WAIT_JNC or TURN.
- `routeDone` out 1: state is DONE.
- `fault` out 1: sticky timeout flag.
- `wrErr` out 1: 1-cycle pulse on a rejected write.

## Operation
- States: IDLE, WAIT_JNC, TURN, DONE, FAULT.
- IDLE:
  - `tdDir`=STOP.
  - Writes accepted when `!full`.
  - `start` with `count>0` → WAIT_JNC, `rdIdx`=0.
  - `start` with `count==0` → DONE.
- WAIT_JNC:
  - `tdDir` = `table[rdIdx]`.
  - `jncArrive` → TURN; the timeout counter is loaded with 0.
- TURN:
  - `tdDir` held.
  - `jncDone` → `rdIdx`+1.
  - If the new `rdIdx == count`, go to DONE; otherwise go to WAIT_JNC.
  - Counter reaching `TIMEOUT_CYC-1` → FAULT.
- DONE: `tdDir`=STOP. `start` restarts from entry 0 (table retained).
- FAULT:
  - `tdDir`=STOP, `fault`=1.
  - Only `clear` or `rst` exits; both go to IDLE.
- Write rejection: a write while `busy`, or while `full`, is not stored, and `wrErr` pulses the next cycle.
- `clear` has priority over every other input in every state. It sets `count`=0, `rdIdx`=0 and `fault`=0.
- Simultaneous events:
  - `jncArrive` and `jncDone` in the same cycle while in WAIT_JNC: treated as arrive only.
  - `jncDone` while in WAIT_JNC: ignored.
  - `jncArrive` while in TURN: ignored.
  - `start` while `busy`: ignored.
  - `wrEn` and `start` in the same cycle in IDLE: the write is stored first, and the new `count` is used for the start decision.

## Timing
- All outputs are registered and update on the `clk` edge after the causing input is sampled.
- Latencies:
  - `start` → `tdDir` valid: 1 cycle.
  - `jncDone` → next entry on `tdDir`: 1 cycle.
- Reset values:
  - `tdDir`=0, `count`=0, `full`=0, `busy`=0, `routeDone`=0, `fault`=0, `wrErr`=0.
  - State = IDLE, `rdIdx`=0.
  - Table contents are don't-care.
- Asserting `rst` mid-route aborts immediately. `tdDir` goes to STOP asynchronously.
- Timeout counter: 28 bits, saturating. It counts only in TURN.

## Configuration
- `ROUTE_LOOP_EN` defined:
  - In TURN, when `jncDone` makes `rdIdx == count`, `rdIdx` wraps to 0 and the state returns to WAIT_JNC.
  - DONE is unreachable except through `start` with an empty table.
  - `routeDone` stays 0 while looping.
- `ROUTE_LOOP_EN` undefined: the route is executed once, then the block enters DONE (behaviour as in Operation).

## Test plan
- Write LEFT, RIGHT, STRAIGHT; `start`; three arrive/done pairs:
  - `tdDir` = 2, 3, 1 in turn.
  - `routeDone`=1 one cycle after the third `jncDone`.
  - `tdDir`=0 afterwards.
- Write 16 entries, then a 17th: `full`=1, `wrErr` pulses once, `count` stays 16.
- `start` with an empty table: DONE next cycle, `tdDir`=0, `busy` never asserted.
- `jncArrive`, then no `jncDone` for `TIMEOUT_CYC` cycles (parameter overridden to 100):
  - `fault`=1 on the 100th TURN cycle, `tdDir`=0.
  - `start` is ignored until `clear`.
- `rst` asserted during TURN, and `wrEn` attempted while `busy`:
  - `rst`: all outputs return to reset values without waiting for a clock edge.
  - `wrEn` while `busy`: `wrErr` pulses and `count` is unchanged.
- With `ROUTE_LOOP_EN` and a 2-entry route (BACK, LEFT), five junctions: `tdDir` sequence 4, 2, 4, 2, 4, and `routeDone` stays 0.

Source files
------------

// File: rtl/route_sequencer_if.sv
// Handshake/bus bundle between the drive block and route_sequencer.
// master drives commands and junction pulses; slave is the sequencer.
interface route_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wrEn;
   logic [2:0]    wrDir;
   logic          start;
   logic          clear;
   logic          jncArrive;
   logic          jncDone;
   logic [2:0]    tdDir;
   logic [CW-1:0] count;
   logic          full;
   logic          busy;
   logic          routeDone;
   logic          fault;
   logic          wrErr;

   modport master (
      output wrEn, wrDir, start, clear, jncArrive, jncDone,
      input  tdDir, count, full, busy, routeDone, fault, wrErr
   );

   modport slave (
      input  wrEn, wrDir, start, clear, jncArrive, jncDone,
      output tdDir, count, full, busy, routeDone, fault, wrErr
   );
endinterface

// File: rtl/route_sequencer.sv
// Junction-decision sequencer: replays a stored turn list with a TURN watchdog.
// Define ROUTE_LOOP_EN to replay the route endlessly instead of stopping in DONE.
module route_sequencer #(
   parameter int DEPTH       = 16,
   parameter int TIMEOUT_CYC = 200_000_000
) (
   input logic               clk,
   input logic               rst,
   route_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_TURN  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [2:0]  D_STOP   = 3'd0;
   localparam logic [27:0] TMO_LAST = 28'(TIMEOUT_CYC - 1);

   logic [2:0]    r_state;
   logic [2:0]    r_tbl [DEPTH];
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_rdIdx;
   logic [2:0]    r_tdDir;
   logic          r_fault;
   logic          r_wrErr;
   logic [27:0]   r_tmr;

   logic          w_busy;
   logic          w_full;
   logic          w_wrOk;
   logic          w_wrRej;
   logic [2:0]    w_wrDir;
   logic [CW-1:0] w_cntNxt;
   logic [2:0]    w_dir0;
   logic [CW-1:0] w_idxNxt;
   logic [2:0]    w_dirNxt;
   logic [27:0]   w_tmrNxt;

   assign w_busy   = (r_state == S_WAIT) || (r_state == S_TURN);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_wrOk   = bus.wrEn && !bus.clear && !w_busy && !w_full;
   assign w_wrRej  = bus.wrEn && !bus.clear && (w_busy || w_full);
   assign w_wrDir  = (bus.wrDir > 3'd4) ? D_STOP : bus.wrDir;
   assign w_cntNxt = w_wrOk ? r_count + 1'b1 : r_count;
   // A write landing in the same cycle as start may be entry 0 itself
   assign w_dir0   = (w_wrOk && r_count == '0) ? w_wrDir : r_tbl[0];
   assign w_idxNxt = r_rdIdx + 1'b1;
   assign w_dirNxt = r_tbl[w_idxNxt[AW-1:0]];
   assign w_tmrNxt = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;

   always_ff @(posedge clk) begin
      if (w_wrOk) begin
         r_tbl[r_count[AW-1:0]] <= w_wrDir;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_rdIdx <= '0;
         r_tdDir <= D_STOP;
         r_fault <= 1'b0;
         r_wrErr <= 1'b0;
         r_tmr   <= '0;
      end else begin
         r_wrErr <= w_wrRej;
         if (bus.clear) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rdIdx <= '0;
            r_tdDir <= D_STOP;
            r_fault <= 1'b0;
            r_tmr   <= '0;
         end else begin
            r_count <= w_cntNxt;
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     r_rdIdx <= '0;
                     if (w_cntNxt != '0) begin
                        r_state <= S_WAIT;
                        r_tdDir <= w_dir0;
                     end else begin
                        r_state <= S_DONE;
                        r_tdDir <= D_STOP;
                     end
                  end
               end
               S_WAIT: begin
                  if (bus.jncArrive) begin
                     r_state <= S_TURN;
                     r_tmr   <= '0;
                  end
               end
               S_TURN: begin
                  if (bus.jncDone) begin
                     if (w_idxNxt == r_count) begin
`ifdef ROUTE_LOOP_EN
                        r_rdIdx <= '0;
                        r_state <= S_WAIT;
                        r_tdDir <= r_tbl[0];
`else
                        r_rdIdx <= w_idxNxt;
                        r_state <= S_DONE;
                        r_tdDir <= D_STOP;
`endif
                     end else begin
                        r_rdIdx <= w_idxNxt;
                        r_state <= S_WAIT;
                        r_tdDir <= w_dirNxt;
                     end
                  end else begin
                     r_tmr <= w_tmrNxt;
                     if (w_tmrNxt == TMO_LAST) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_tdDir <= D_STOP;
                     end
                  end
               end
               S_FAULT: begin
                  r_tdDir <= D_STOP;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_tdDir <= D_STOP;
               end
            endcase
         end
      end
   end

   assign bus.tdDir     = r_tdDir;
   assign bus.count     = r_count;
   assign bus.full      = w_full;
   assign bus.busy      = w_busy;
   assign bus.routeDone = (r_state == S_DONE);
   assign bus.fault     = r_fault;
   assign bus.wrErr     = r_wrErr;
endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer with a 100-cycle watchdog.
// Build with +define+ROUTE_LOOP_EN to exercise the looping variant.
module tb_route_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   route_sequencer_if #(.DEPTH(16)) bus ();

   route_sequencer #(
      .DEPTH       (16),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] d);
      bus.wrEn  = 1'b1;
      bus.wrDir = d;
      step();
      bus.wrEn  = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   task automatic arrive();
      bus.jncArrive = 1'b1;
      step();
      bus.jncArrive = 1'b0;
   endtask

   task automatic done();
      bus.jncDone = 1'b1;
      step();
      bus.jncDone = 1'b0;
   endtask

   initial begin
      bus.wrEn      = 1'b0;
      bus.wrDir     = 3'd0;
      bus.start     = 1'b0;
      bus.clear     = 1'b0;
      bus.jncArrive = 1'b0;
      bus.jncDone   = 1'b0;

      // reset state
      step();
      step();
      chk("rst_tdDir", 32'(bus.tdDir), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.routeDone), 0);
      chk("rst_fault", 32'(bus.fault), 0);
      chk("rst_wrErr", 32'(bus.wrErr), 0);
      rst = 1'b0;
      step();

      // basic three-junction route
      wr(3'd2);
      wr(3'd3);
      wr(3'd1);
      chk("r1_count", 32'(bus.count), 3);
      pulse_start();
      chk("r1_busy", 32'(bus.busy), 1);
      chk("r1_dir0", 32'(bus.tdDir), 2);
      arrive();
      chk("r1_dir0_turn", 32'(bus.tdDir), 2);
      done();
      chk("r1_dir1", 32'(bus.tdDir), 3);
      arrive();
      done();
      chk("r1_dir2", 32'(bus.tdDir), 1);
      arrive();
      done();
`ifdef ROUTE_LOOP_EN
      chk("r1_wrap_dir", 32'(bus.tdDir), 2);
      chk("r1_wrap_done", 32'(bus.routeDone), 0);
      chk("r1_wrap_busy", 32'(bus.busy), 1);
`else
      chk("r1_routeDone", 32'(bus.routeDone), 1);
      chk("r1_end_dir", 32'(bus.tdDir), 0);
      chk("r1_end_busy", 32'(bus.busy), 0);
      pulse_start();
      chk("r1_restart_dir", 32'(bus.tdDir), 2);
      chk("r1_restart_done", 32'(bus.routeDone), 0);
`endif
      pulse_clear();
      chk("clr_count", 32'(bus.count), 0);
      chk("clr_busy", 32'(bus.busy), 0);
      chk("clr_dir", 32'(bus.tdDir), 0);

      // write while busy, code 7 stored as STOP, async reset in TURN
      wr(3'd1);
      wr(3'd7);
      pulse_start();
      chk("wb_dir0", 32'(bus.tdDir), 1);
      wr(3'd3);
      chk("wb_wrErr", 32'(bus.wrErr), 1);
      chk("wb_count", 32'(bus.count), 2);
      step();
      chk("wb_wrErr_end", 32'(bus.wrErr), 0);
      arrive();
      done();
      chk("wb_code7_dir", 32'(bus.tdDir), 0);
      chk("wb_code7_busy", 32'(bus.busy), 1);
      arrive();
      #2;
      rst = 1'b1;
      #1;
      chk("ar_tdDir", 32'(bus.tdDir), 0);
      chk("ar_busy", 32'(bus.busy), 0);
      chk("ar_count", 32'(bus.count), 0);
      chk("ar_wrErr", 32'(bus.wrErr), 0);
      step();
      rst = 1'b0;
      step();

      // fill to DEPTH, then one rejected write
      for (int i = 0; i < 16; i++) begin
         wr(3'(i % 5));
      end
      chk("fl_count", 32'(bus.count), 16);
      chk("fl_full", 32'(bus.full), 1);
      chk("fl_wrErr0", 32'(bus.wrErr), 0);
      wr(3'd2);
      chk("fl_wrErr", 32'(bus.wrErr), 1);
      chk("fl_count17", 32'(bus.count), 16);
      step();
      chk("fl_wrErr_end", 32'(bus.wrErr), 0);
      pulse_clear();
      chk("fl_clr_full", 32'(bus.full), 0);

      // empty-table start
      pulse_start();
      chk("em_done", 32'(bus.routeDone), 1);
      chk("em_busy", 32'(bus.busy), 0);
      chk("em_dir", 32'(bus.tdDir), 0);
      step();
      chk("em_busy2", 32'(bus.busy), 0);
      pulse_clear();
      chk("em_clr_done", 32'(bus.routeDone), 0);

      // watchdog: fault in the 100th TURN cycle
      wr(3'd3);
      pulse_start();
      chk("to_dir", 32'(bus.tdDir), 3);
      arrive();
      repeat (98) step();
      chk("to_fault_pre", 32'(bus.fault), 0);
      chk("to_dir_pre", 32'(bus.tdDir), 3);
      step();
      chk("to_fault", 32'(bus.fault), 1);
      chk("to_dir_stop", 32'(bus.tdDir), 0);
      chk("to_busy", 32'(bus.busy), 0);
      pulse_start();
      chk("to_start_fault", 32'(bus.fault), 1);
      chk("to_start_busy", 32'(bus.busy), 0);
      chk("to_start_dir", 32'(bus.tdDir), 0);
      pulse_clear();
      chk("to_clr_fault", 32'(bus.fault), 0);
      chk("to_clr_count", 32'(bus.count), 0);

      // arrive+done together in WAIT_JNC acts as arrive only
      wr(3'd2);
      wr(3'd3);
      pulse_start();
      bus.jncArrive = 1'b1;
      bus.jncDone   = 1'b1;
      step();
      bus.jncArrive = 1'b0;
      bus.jncDone   = 1'b0;
      chk("sim_dir", 32'(bus.tdDir), 2);
      chk("sim_busy", 32'(bus.busy), 1);
      done();
      chk("sim_next", 32'(bus.tdDir), 3);
      pulse_clear();

      // write and start together on an empty table
      bus.wrEn  = 1'b1;
      bus.wrDir = 3'd2;
      bus.start = 1'b1;
      step();
      bus.wrEn  = 1'b0;
      bus.start = 1'b0;
      chk("ws_busy", 32'(bus.busy), 1);
      chk("ws_dir", 32'(bus.tdDir), 2);
      chk("ws_count", 32'(bus.count), 1);
      pulse_clear();

`ifdef ROUTE_LOOP_EN
      // looping 2-entry route over five junctions
      wr(3'd4);
      wr(3'd2);
      pulse_start();
      chk("lp_dir0", 32'(bus.tdDir), 4);
      arrive();
      done();
      chk("lp_dir1", 32'(bus.tdDir), 2);
      arrive();
      done();
      chk("lp_dir2", 32'(bus.tdDir), 4);
      chk("lp_done2", 32'(bus.routeDone), 0);
      arrive();
      done();
      chk("lp_dir3", 32'(bus.tdDir), 2);
      arrive();
      done();
      chk("lp_dir4", 32'(bus.tdDir), 4);
      chk("lp_done4", 32'(bus.routeDone), 0);
      pulse_clear();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
